// File: rtl/tof_udp_pkg.sv
// tof_udp_pkg: shared word width, flow-buffer packet limit, arbiter state encoding and clog2 helper.
package tof_udp_pkg;
    localparam int HELIX_WORD_W = 16;
    localparam int TOF_UDP_MAX_WORDS = 1024;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DISCARD = 2'd2
    } arb_state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/tof_rr_arbiter.sv
// tof_rr_arbiter: round-robin pick of the first request after the pointer, wrapping; the
// pointer moves to the winner only when the caller commits the grant with i_grant_en.
module tof_rr_arbiter
    import tof_udp_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_grant_en,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any
);
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_j;
    always_comb begin
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_j         = '0;
        for (int k = 1; k <= N; k++) begin
            w_j = IW'((int'(r_ptr) + k) % N);
            if (!o_any && i_req[w_j]) begin
                o_any       = 1'b1;
                o_grant_idx = w_j;
            end
        end
    end
    // Reset to the last source so source 0 wins the first round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= IW'(N - 1);
        else if (i_grant_en && o_any)
            r_ptr <= o_grant_idx;
    end
endmodule

// File: rtl/tof_udp_packet_arbiter.sv
// tof_udp_packet_arbiter: packet-level round-robin merge of HELIX-framed sources into the TOF UDP
// flow buffer. Optional TOF_UDP_ARB_LENGTH_GUARD_EN drops 1-word packets and truncates overlong ones.
module tof_udp_packet_arbiter
    import tof_udp_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_WORDS = TOF_UDP_MAX_WORDS,
    localparam int IW = clog2(NUM_SRC),
    localparam int CW = clog2(MAX_WORDS + 1)
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_aresetn,
    input  logic [NUM_SRC-1:0]              src_enable,
    input  logic [HELIX_WORD_W*NUM_SRC-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    input  logic [NUM_SRC-1:0]              s_axis_tuser,
    output logic [HELIX_WORD_W-1:0]         m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tuser,
    output logic [IW-1:0]                   grant_src,
    output logic                            busy
`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
    ,
    output logic                            len_drop_pulse,
    output logic                            len_trunc_pulse
`endif
);
    arb_state_t              r_state;
    logic [IW-1:0]           r_grant;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           w_pick;
    logic                    w_any;
    logic                    w_stream;
    logic                    w_beat;
    logic                    w_at_max;
    logic                    w_src_last;
    logic [NUM_SRC-1:0]      w_cand;
    logic [NUM_SRC-1:0]      w_junk;
    logic [NUM_SRC-1:0]      w_single;
    logic [HELIX_WORD_W-1:0] w_words [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
        assign w_words[i] = s_axis_tdata[HELIX_WORD_W*i +: HELIX_WORD_W];
    end

    assign w_junk = s_axis_tvalid & ~s_axis_tuser & src_enable;
`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
    // A packet that starts and ends on one beat is never legal; swallow it in IDLE.
    assign w_single = s_axis_tvalid & s_axis_tuser & s_axis_tlast & src_enable;
    assign w_cand   = s_axis_tvalid & s_axis_tuser & ~s_axis_tlast & src_enable;
    assign w_at_max = r_cnt == CW'(MAX_WORDS - 1);
`else
    assign w_single = '0;
    assign w_cand   = s_axis_tvalid & s_axis_tuser & src_enable;
    assign w_at_max = 1'b0;
`endif

    tof_rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_rr (
        .clk         (s_axis_aclk),
        .rst_n       (s_axis_aresetn),
        .i_req       (w_cand),
        .i_grant_en  (r_state == IDLE),
        .o_grant_idx (w_pick),
        .o_any       (w_any)
    );

    assign w_stream   = r_state == STREAM;
    assign w_src_last = s_axis_tlast[r_grant];
    assign w_beat     = m_axis_tvalid & m_axis_tready;
    assign grant_src  = r_grant;
    assign busy       = r_state != IDLE;

    always_comb begin
        m_axis_tvalid = w_stream & s_axis_tvalid[r_grant];
        m_axis_tdata  = w_stream ? w_words[r_grant] : '0;
        m_axis_tuser  = w_stream & s_axis_tuser[r_grant];
        m_axis_tlast  = w_stream & (w_src_last | w_at_max);
        s_axis_tready = '0;
        if (r_state == IDLE)
            s_axis_tready = w_junk | w_single;
        else
            s_axis_tready[r_grant] = w_stream ? m_axis_tready : 1'b1;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_state <= STREAM;
                    r_grant <= w_pick;
                    r_cnt   <= '0;
                end
                STREAM: if (w_beat) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_src_last)
                        r_state <= IDLE;
                    else if (w_at_max)
                        r_state <= DISCARD;
                end
                DISCARD: if (s_axis_tvalid[r_grant] && w_src_last)
                    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            len_drop_pulse  <= 1'b0;
            len_trunc_pulse <= 1'b0;
        end else begin
            len_drop_pulse  <= (r_state == IDLE) && (|w_single);
            len_trunc_pulse <= w_stream && w_beat && w_at_max && !w_src_last;
        end
    end
`endif
endmodule

// File: tb/tb_tof_udp_packet_arbiter.sv
// tb_tof_udp_packet_arbiter: directed bench for the packet arbiter; the length-guard scenario
// runs only when TOF_UDP_ARB_LENGTH_GUARD_EN is defined.
`timescale 1ns/1ps
module tb_tof_udp_packet_arbiter;
    localparam int N = 4;
    typedef struct packed {
        logic [15:0] d;
        logic        u;
        logic        l;
        logic [1:0]  g;
        logic [31:0] c;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  src_enable = '1;
    logic [16*N-1:0] s_tdata = '0;
    logic [N-1:0]  s_tvalid = '0;
    logic [N-1:0]  s_tready;
    logic [N-1:0]  s_tlast = '0;
    logic [N-1:0]  s_tuser = '0;
    logic [15:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          m_tlast;
    logic          m_tuser;
    logic [1:0]    grant_src;
    logic          busy;
`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
    logic          drop_p;
    logic          trunc_p;
`endif

    beat_t         mon[$];
    beat_t         last_b;
    logic [17:0]   q[N][$];
    logic [17:0]   drv_w;
    logic [N-1:0]  hs;
    logic          toggle = 1'b0;
    logic          stalled = 1'b0;
    logic [15:0]   stall_d = '0;
    logic [31:0]   c_a, c_b;
    int            n_checks = 0, n_errors = 0, cyc = 0, drops = 0, truncs = 0;

    always #5 clk = ~clk;

    tof_udp_packet_arbiter dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .src_enable     (src_enable),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .s_axis_tuser   (s_tuser),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .m_axis_tuser   (m_tuser),
        .grant_src      (grant_src),
        .busy           (busy)
`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
        ,
        .len_drop_pulse (drop_p),
        .len_trunc_pulse(trunc_p)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic post(input int s, input int n, input logic [15:0] base);
        for (int w = 0; w < n; w++) q[s].push_back({w == 0, w == n - 1, base + 16'(w)});
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && mon.size() < n; i++) @(posedge clk);
        #1;
        check(tag, mon.size(), n);
    endtask

    task automatic exp_pkt(input string tag, input int s, input int n, input logic [15:0] base,
                           output logic [31:0] c_first);
        beat_t b;
        c_first = '0;
        for (int w = 0; w < n; w++) begin
            b = mon.size() > 0 ? mon.pop_front() : '0;
            if (w == 0) begin
                c_first = b.c;
                check({tag, "_grant"}, 32'(b.g), s);
            end
            check(tag, {b.d, b.u, b.l}, {base + 16'(w), w == 0, w == n - 1});
            last_b = b;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        repeat (3) @(negedge clk);
        mon.delete();
        drops = 0;
        truncs = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Source drivers: handshake sampled mid-cycle, queue advanced just after the edge.
    initial forever begin
        @(negedge clk);
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
        for (int i = 0; i < N; i++) begin
            drv_w = q[i].size() > 0 ? q[i][0] : 18'd0;
            s_tvalid[i] = q[i].size() > 0;
            s_tuser[i] = drv_w[17];
            s_tlast[i] = drv_w[16];
            s_tdata[16*i +: 16] = drv_w[15:0];
        end
        if (toggle) m_tready = ~m_tready;
    end

    initial forever begin
        @(negedge clk);
        cyc++;
        if (stalled) begin
            check("stall_valid", 32'(m_tvalid), 1);
            check("stall_data", 32'(m_tdata), 32'(stall_d));
        end
        stalled = m_tvalid & ~m_tready;
        stall_d = m_tdata;
        if (m_tvalid && m_tready) mon.push_back({m_tdata, m_tuser, m_tlast, grant_src, 32'(cyc)});
`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
        drops += int'(drop_p);
        truncs += int'(trunc_p);
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_mvalid", 32'(m_tvalid), 0);
        check("rst_grant", 32'(grant_src), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tready", 32'(s_tready), 0);
        do_reset();

        // 1: src0 and src2 together; src0 first, one idle cycle between packets
        post(0, 4, 16'h0100);
        post(2, 4, 16'h2100);
        wait_beats("t1_beats", 8, 40);
        exp_pkt("t1_src0", 0, 4, 16'h0100, c_a);
        c_a = last_b.c;
        exp_pkt("t1_src2", 2, 4, 16'h2100, c_b);
        check("t1_gap", c_b - c_a, 2);

        // 2: all sources continuously, two 3-word packets each
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) post(s, 3, {4'(s), 4'(p), 8'h00});
        wait_beats("t2_beats", 24, 200);
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) exp_pkt("t2_pkt", s, 3, {4'(s), 4'(p), 8'h00}, c_a);

        // 3: downstream ready toggling during a 6-word packet
        post(1, 6, 16'h1300);
        toggle = 1'b1;
        wait_beats("t3_beats", 6, 80);
        toggle = 1'b0;
        m_tready = 1'b1;
        exp_pkt("t3_src1", 1, 6, 16'h1300, c_a);
        check("t3_span", 32'((last_b.c - c_a) >= 10), 1);

        // 4: disabled source never granted; enable dropped mid-packet still completes
        src_enable[1] = 1'b0;
        post(1, 3, 16'h1400);
        post(2, 6, 16'h2400);
        wait_beats("t4_two", 2, 40);
        src_enable[2] = 1'b0;
        wait_beats("t4_beats", 6, 60);
        exp_pkt("t4_src2", 2, 6, 16'h2400, c_a);
        post(2, 3, 16'h2410);
        repeat (20) @(posedge clk);
        #1;
        check("t4_blocked", mon.size(), 0);
        check("t4_tready", 32'(s_tready[2:1]), 0);
        check("t4_grant", 32'(grant_src), 2);
        check("t4_busy", 32'(busy), 0);
        q[1].delete();
        q[2].delete();
        src_enable = '1;
        repeat (2) @(posedge clk);

`ifdef TOF_UDP_ARB_LENGTH_GUARD_EN
        // 5: 1-word packet dropped, 1030-word packet truncated to 1024
        do_reset();
        post(3, 1, 16'h3500);
        repeat (6) @(posedge clk);
        #1;
        check("t5_drop_beats", mon.size(), 0);
        check("t5_drops", drops, 1);
        check("t5_q_single", q[3].size(), 0);
        post(3, 1030, 16'h0000);
        wait_beats("t5_beats", 1024, 1500);
        repeat (20) @(posedge clk);
        #1;
        check("t5_total", mon.size(), 1024);
        begin
            int nlast, bad;
            beat_t b;
            nlast = 0;
            bad = 0;
            b = '0;
            for (int i = 0; i < 1024; i++) begin
                b = mon.size() > 0 ? mon.pop_front() : '0;
                nlast += int'(b.l);
                if (b.d !== 16'(i) || b.u !== (i == 0)) bad++;
            end
            check("t5_last_cnt", nlast, 1);
            check("t5_data_bad", bad, 0);
            check("t5_final_last", 32'(b.l), 1);
            check("t5_final_data", 32'(b.d), 1023);
        end
        check("t5_trunc", truncs, 1);
        check("t5_q_drained", q[3].size(), 0);
        check("t5_busy", 32'(busy), 0);
`endif

        // 6: reset during word 3 of 8, then arbitration restarts at src0
        do_reset();
        post(2, 8, 16'h2600);
        wait_beats("t6_pre", 2, 40);
        #1 rst_n = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        #1;
        check("t6_mvalid", 32'(m_tvalid), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_grant", 32'(grant_src), 0);
        repeat (2) @(negedge clk);
        mon.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        post(0, 2, 16'h0600);
        post(3, 2, 16'h3600);
        wait_beats("t6_beats", 4, 40);
        exp_pkt("t6_src0", 0, 2, 16'h0600, c_a);
        exp_pkt("t6_src3", 3, 2, 16'h3600, c_a);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
